// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI-to-Wishbone bridge.
package obi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;

    // Default-width OBI address-phase bundle.
    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
    } obi_req_t;

    // Width of a port index; at least one bit even for a single port.
    function automatic int unsigned port_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/obi_wb_bridge_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, priority starting
// at the port after the last accepted one. Pointer moves only on accept.
module rr_arbiter
    import obi_wb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             req,
    input  logic                     accept,
    output logic [N-1:0]             gnt,
    output logic [port_idx_w(N)-1:0] idx
);

    localparam int unsigned IW = port_idx_w(N);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;
    logic          found;

    // Scan ports last+1, last+2, ... (wrapping) and pick the first requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    // Last-granted pointer; reset to N-1 so port 0 has first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last <= IW'(N - 1);
        end else if (accept) begin
            last <= idx;
        end
    end

endmodule

// File: rtl/obi_wb_bridge.sv
// OBI (NUM_PORTS slave ports) to classic Wishbone master bridge.
// Round-robin arbitration, one outstanding transfer, rvalid one cycle after
// the Wishbone ack/err. Optional Wishbone wait timeout: OBI_WB_TIMEOUT_EN.
module obi_wb_bridge
    import obi_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PORTS-1:0]                obi_req_i,
    output logic [NUM_PORTS-1:0]                obi_gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic [NUM_PORTS-1:0]                obi_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     obi_wdata_i,
    output logic [NUM_PORTS-1:0]                obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]               obi_rdata_o,
    output logic                                obi_err_o,
    output logic                                wb_cyc_o,
    output logic                                wb_stb_o,
    output logic                                wb_we_o,
    output logic [DATA_WIDTH/8-1:0]             wb_sel_o,
    output logic [ADDR_WIDTH-1:0]               wb_adr_o,
    output logic [DATA_WIDTH-1:0]               wb_dat_o,
    input  logic [DATA_WIDTH-1:0]               wb_dat_i,
    input  logic                                wb_ack_i,
    input  logic                                wb_err_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IW       = port_idx_w(NUM_PORTS);

    // Address-phase bundle sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_e         state, state_next;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic [IW-1:0]  owner;
    logic           accept;
    logic           done;
    logic           timeout_hit;
    req_t           winner;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (obi_req_i),
        .accept (accept),
        .gnt    (arb_gnt),
        .idx    (arb_idx)
    );

    // Select the arbitration winner's address-phase fields.
    always_comb begin
        winner.addr  = obi_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
        winner.we    = obi_we_i[arb_idx];
        winner.be    = obi_be_i[arb_idx*BE_WIDTH +: BE_WIDTH];
        winner.wdata = obi_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef OBI_WB_TIMEOUT_EN
    localparam int unsigned TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_W     = (TO_W_RAW < 8) ? 8 : ((TO_W_RAW > 16) ? 16 : TO_W_RAW);

    logic [TO_W-1:0] to_cnt;

    // Wait counter: cleared on every grant, counts cycles spent in BUS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (accept) begin
            to_cnt <= '0;
        end else if (state == BUS) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == BUS) && !wb_ack_i && !wb_err_i
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign done = wb_ack_i | wb_err_i | timeout_hit;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grant: grants only when no Wishbone cycle is in flight.
    always_comb begin
        state_next = state;
        obi_gnt_o  = '0;
        accept     = 1'b0;
        case (state)
            IDLE, RESP: begin
                obi_gnt_o  = arb_gnt;
                accept     = |arb_gnt;
                state_next = accept ? BUS : IDLE;
            end
            BUS: begin
                if (done) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wishbone request registers and captured response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner       <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            obi_rdata_o <= '0;
            obi_err_o   <= 1'b0;
        end else if (accept) begin
            owner    <= arb_idx;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= winner.we;
            wb_sel_o <= winner.be;
            wb_adr_o <= winner.addr;
            wb_dat_o <= winner.wdata;
        end else if ((state == BUS) && done) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            obi_err_o   <= wb_err_i | timeout_hit;
            obi_rdata_o <= (wb_err_i || timeout_hit || wb_we_o) ? '0 : wb_dat_i;
        end
    end

    // Response valid pulse to the owning port during RESP.
    always_comb begin
        obi_rvalid_o = '0;
        if (state == RESP) begin
            obi_rvalid_o[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Self-checking bench for obi_wb_bridge (2 ports, 32-bit, TIMEOUT_CYCLES=4).
// Directed scenarios followed by randomized traffic against a transaction model.
module tb_obi_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  obi_req, obi_gnt, obi_we, obi_rvalid;
    logic [63:0] obi_addr, obi_wdata;
    logic [7:0]  obi_be;
    logic [31:0] obi_rdata;
    logic        obi_err;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;

    obi_wb_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .NUM_PORTS      (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .obi_req_i    (obi_req),
        .obi_gnt_o    (obi_gnt),
        .obi_addr_i   (obi_addr),
        .obi_we_i     (obi_we),
        .obi_be_i     (obi_be),
        .obi_wdata_i  (obi_wdata),
        .obi_rvalid_o (obi_rvalid),
        .obi_rdata_o  (obi_rdata),
        .obi_err_o    (obi_err),
        .wb_cyc_o     (wb_cyc),
        .wb_stb_o     (wb_stb),
        .wb_we_o      (wb_we),
        .wb_sel_o     (wb_sel),
        .wb_adr_o     (wb_adr),
        .wb_dat_o     (wb_dat_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack),
        .wb_err_i     (wb_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic w,
                            input logic [3:0] b, input logic [31:0] d);
        obi_req[p]          = 1'b1;
        obi_addr[p*32 +: 32] = a;
        obi_we[p]           = w;
        obi_be[p*4 +: 4]    = b;
        obi_wdata[p*32 +: 32] = d;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        obi_req = '0;
        wb_ack  = 1'b0;
        wb_err  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Transaction-level reference model state
    int          m_last, m_owner, m_rsp_port;
    bit          m_busy, m_cyc, m_rsp, m_rsp_err;
    logic [31:0] m_rsp_data, t_addr, t_wdata;
    logic        t_we;
    logic [3:0]  t_be;
    logic [1:0]  drop;
    bit          s_active;
    int          s_wait;

    task automatic rand_cycle();
        int         w;
        int         kind;
        logic [1:0] exp_g;
        tick();
        // masters: drop granted requests, maybe start new ones
        for (int p = 0; p < 2; p++) begin
            if (drop[p]) obi_req[p] = 1'b0;
            if (!obi_req[p] && $urandom_range(0, 2) == 0)
                set_port(p, $urandom, 1'($urandom_range(0, 1)),
                         4'($urandom_range(1, 15)), $urandom);
        end
        drop = '0;
        // slave: random wait, then ack, err or both
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_i = $urandom;
        if (wb_cyc && wb_stb) begin
            if (!s_active) begin
                s_active = 1'b1;
                s_wait   = $urandom_range(0, 3);
            end
            if (s_wait == 0) begin
                kind     = $urandom_range(0, 5);
                wb_ack   = (kind != 4);
                wb_err   = (kind >= 4);
                s_active = 1'b0;
            end else begin
                s_wait--;
            end
        end
        settle();
        // response expected one cycle after completion
        check_eq("rnd_rvalid", obi_rvalid, m_rsp ? (64'd1 << m_rsp_port) : 64'd0);
        if (m_rsp) begin
            check_eq("rnd_rdata", obi_rdata, m_rsp_data);
            check_eq("rnd_err", obi_err, m_rsp_err);
        end
        // round-robin winner among current requesters when no transfer in flight
        exp_g = '0;
        w     = -1;
        if (!m_busy) begin
            for (int k = 1; k <= 2; k++) begin
                int c;
                c = (m_last + k) % 2;
                if (w < 0 && obi_req[c]) w = c;
            end
        end
        if (w >= 0) exp_g[w] = 1'b1;
        check_eq("rnd_gnt", obi_gnt, exp_g);
        check_eq("rnd_cyc", wb_cyc, m_cyc);
        check_eq("rnd_stb", wb_stb, m_cyc);
        if (m_cyc) begin
            check_eq("rnd_adr", wb_adr, t_addr);
            check_eq("rnd_we", wb_we, t_we);
            check_eq("rnd_sel", wb_sel, t_be);
            check_eq("rnd_dat", wb_dat_o, t_wdata);
        end
        // advance model to next cycle
        m_rsp = 1'b0;
        if (m_cyc && (wb_ack || wb_err)) begin
            m_rsp      = 1'b1;
            m_rsp_port = m_owner;
            m_rsp_err  = wb_err;
            m_rsp_data = (wb_err || t_we) ? 32'd0 : wb_dat_i;
            m_busy     = 1'b0;
            m_cyc      = 1'b0;
        end
        if (w >= 0) begin
            m_busy  = 1'b1;
            m_cyc   = 1'b1;
            m_owner = w;
            m_last  = w;
            t_addr  = obi_addr[w*32 +: 32];
            t_we    = obi_we[w];
            t_be    = obi_be[w*4 +: 4];
            t_wdata = obi_wdata[w*32 +: 32];
            drop[w] = 1'b1;
        end
    endtask

    initial begin
        int n;
        bit got_rv;
        bit rv_err;

        rst_n = 1'b0; obi_req = '0; obi_we = '0; obi_addr = '0; obi_be = '0;
        obi_wdata = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
        tick(); tick(); settle();
        check_eq("rst_gnt", obi_gnt, 0);
        check_eq("rst_rvalid", obi_rvalid, 0);
        check_eq("rst_rdata", obi_rdata, 0);
        check_eq("rst_err", obi_err, 0);
        check_eq("rst_cyc", wb_cyc, 0);
        check_eq("rst_stb", wb_stb, 0);
        check_eq("rst_we", wb_we, 0);
        check_eq("rst_sel", wb_sel, 0);
        check_eq("rst_adr", wb_adr, 0);
        check_eq("rst_dat", wb_dat_o, 0);
        rst_n = 1'b1;

        // Port0 read, zero-wait slave
        tick();
        set_port(0, 32'h1000, 1'b0, 4'hF, 32'h0);
        settle();
        check_eq("t1_gnt", obi_gnt, 2'b01);
        check_eq("t1_cyc_t0", wb_cyc, 0);
        tick();
        obi_req = '0; wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
        settle();
        check_eq("t1_cyc_t1", wb_cyc, 1);
        check_eq("t1_stb_t1", wb_stb, 1);
        check_eq("t1_adr", wb_adr, 32'h1000);
        check_eq("t1_we", wb_we, 0);
        check_eq("t1_rvalid_t1", obi_rvalid, 0);
        tick();
        wb_ack = 1'b0; wb_dat_i = '0;
        settle();
        check_eq("t1_rvalid_t2", obi_rvalid, 2'b01);
        check_eq("t1_rdata", obi_rdata, 32'hDEADBEEF);
        check_eq("t1_err", obi_err, 0);
        check_eq("t1_cyc_t2", wb_cyc, 0);
        tick(); settle();
        check_eq("t1_rvalid_t3", obi_rvalid, 0);

        // Port1 write with 3 wait cycles; port0 waits, then back-to-back read with ack+err
        tick();
        set_port(1, 32'h2004, 1'b1, 4'b0011, 32'h12345678);
        settle();
        check_eq("t3_gnt", obi_gnt, 2'b10);
        tick();
        obi_req[1] = 1'b0;
        set_port(0, 32'h3000, 1'b0, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("t3_wait_cyc", wb_cyc, 1);
            check_eq("t3_wait_sel", wb_sel, 4'b0011);
            check_eq("t3_wait_dat", wb_dat_o, 32'h12345678);
            check_eq("t3_wait_adr", wb_adr, 32'h2004);
            check_eq("t3_wait_we", wb_we, 1);
            check_eq("t3_no_gnt_in_bus", obi_gnt, 0);
            tick();
        end
        wb_ack = 1'b1; wb_dat_i = 32'hCAFEF00D;
        settle();
        check_eq("t3_ack_cyc", wb_cyc, 1);
        tick();
        wb_ack = 1'b0;
        settle();
        check_eq("t3_rvalid", obi_rvalid, 2'b10);
        check_eq("t3_rdata_wr", obi_rdata, 0);
        check_eq("t3_err", obi_err, 0);
        check_eq("t4_b2b_gnt", obi_gnt, 2'b01);
        tick();
        obi_req[0] = 1'b0; wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'hFFFFFFFF;
        settle();
        check_eq("t4_cyc", wb_cyc, 1);
        check_eq("t4_adr", wb_adr, 32'h3000);
        tick();
        wb_ack = 1'b0; wb_err = 1'b0;
        settle();
        check_eq("t4_rvalid", obi_rvalid, 2'b01);
        check_eq("t4_err", obi_err, 1);
        check_eq("t4_rdata", obi_rdata, 0);
        tick(); settle();
        check_eq("t4_rvalid_end", obi_rvalid, 0);
        check_eq("t4_cyc_end", wb_cyc, 0);

        // Both ports requesting continuously from reset: grants alternate from port 0
        do_reset();
        set_port(0, 32'h100, 1'b0, 4'hF, 32'h0);
        set_port(1, 32'h200, 1'b0, 4'hF, 32'h0);
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            settle();
            if (obi_gnt != 0) begin
                check_eq("t2_alt_gnt", obi_gnt, (n % 2 == 0) ? 2'b01 : 2'b10);
                n++;
            end
            tick();
            wb_ack = wb_cyc;
        end
        check_eq("t2_grant_count", n, 6);
        obi_req = '0;
        tick(); wb_ack = wb_cyc;
        tick(); wb_ack = 1'b0;

        // Reset while in BUS
        do_reset();
        set_port(0, 32'h4000, 1'b0, 4'hF, 32'h0);
        settle();
        check_eq("t5_gnt", obi_gnt, 2'b01);
        tick();
        obi_req = '0;
        settle();
        check_eq("t5_cyc_before", wb_cyc, 1);
        rst_n = 1'b0;
        tick(); settle();
        check_eq("t5_cyc_after", wb_cyc, 0);
        check_eq("t5_stb_after", wb_stb, 0);
        check_eq("t5_rvalid_rst", obi_rvalid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check_eq("t5_no_rvalid", obi_rvalid, 0);
            check_eq("t5_cyc_idle", wb_cyc, 0);
        end

        // Slave never acks
        do_reset();
        set_port(0, 32'h5000, 1'b0, 4'hF, 32'h0);
        settle();
        check_eq("t6_gnt", obi_gnt, 2'b01);
        tick();
        obi_req = '0;
        n = 0; got_rv = 1'b0; rv_err = 1'b0;
        for (int i = 0; i < 12; i++) begin
            settle();
            if (wb_cyc) n++;
            if (obi_rvalid[0]) begin
                got_rv = 1'b1;
                rv_err = obi_err;
            end
            tick();
        end
`ifdef OBI_WB_TIMEOUT_EN
        check_eq("t6_cyc_cycles", n, 4);
        check_eq("t6_timeout_rvalid", got_rv, 1);
        check_eq("t6_timeout_err", rv_err, 1);
`else
        check_eq("t6_cyc_cycles", n, 12);
        check_eq("t6_no_rvalid", got_rv, 0);
        wb_ack = 1'b1; wb_dat_i = 32'h0BADF00D;
        tick();
        wb_ack = 1'b0;
        settle();
        check_eq("t6_late_rvalid", obi_rvalid, 2'b01);
        check_eq("t6_late_rdata", obi_rdata, 32'h0BADF00D);
`endif

        // Randomized traffic against the transaction model
        do_reset();
        m_last = 1; m_busy = 1'b0; m_cyc = 1'b0; m_rsp = 1'b0;
        m_owner = 0; m_rsp_port = 0; m_rsp_err = 1'b0; m_rsp_data = '0;
        drop = '0; s_active = 1'b0; s_wait = 0;
        t_addr = '0; t_we = 1'b0; t_be = '0; t_wdata = '0;
        for (int i = 0; i < 500; i++) begin
            rand_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
